// File: rtl/enc8b10b_lanes.sv
// ---------------------------------------------------------------------------
// enc8b10b_lanes
//   Multi-lane 8b/10b encoder using the 802.3 clause 36 code tables. Encodes
//   LANES bytes per clock. Running disparity (RD) chains lane 0 -> LANES-1
//   inside a word and is carried across clocks. Supports idle insertion
//   (K28.5 on every lane), invalid-K flagging and 1- or 2-stage output
//   pipelining.
//
// Parameters
//   LANES      bytes per clock (1..8); lane 0 is transmitted first
//   PIPE       clocks from input sample to dataout (1 or 2)
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous reset, active low
//   ena        input word valid / encode enable
//   idle_ins   force K28.5 on every lane; wins over ena
//   kin        per-lane control flag
//   datain     lane i = datain[8i+7:8i] (HGFEDCBA, A = bit 0)
//   rdin       external starting RD (0 = RD-, 1 = RD+)
//   rdforce    lane 0 starts from rdin instead of the internal RD register
//   dataout    lane i = dataout[10i+9:10i]; bit0=a..bit5=i, bit6=f..bit9=j
//   kerr       lane had kin=1 with a byte that is not a legal K code
//   valid      dataout holds a newly encoded word
//   rdout      ending RD of the word on dataout
//   rdcascade  combinational ending RD of the word at the inputs
// ---------------------------------------------------------------------------
module enc8b10b_lanes #(
  parameter int LANES = 2,
  parameter int PIPE  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ena,
  input  logic                  idle_ins,
  input  logic [LANES-1:0]      kin,
  input  logic [8*LANES-1:0]    datain,
  input  logic                  rdin,
  input  logic                  rdforce,
  output logic [10*LANES-1:0]   dataout,
  output logic [LANES-1:0]      kerr,
  output logic                  valid,
  output logic                  rdout,
  output logic                  rdcascade
);

  if (PIPE != 1 && PIPE != 2) begin : g_bad_pipe
    $error("enc8b10b_lanes: PIPE must be 1 or 2");
  end
  if (LANES < 1 || LANES > 8) begin : g_bad_lanes
    $error("enc8b10b_lanes: LANES must be 1..8");
  end

  typedef struct packed {
    logic [9:0] code;
    logic       rd;
    logic       kerr;
  } lane_enc_t;

  // Encodes one byte from running disparity rd. Table entries hold
  // {RD- code, RD+ code}, written abcdei / fghj with a as the MSB.
  function automatic lane_enc_t encode_lane(input logic k, input logic [7:0] b,
                                            input logic rd);
    logic [4:0]  x;
    logic [2:0]  y;
    logic        k28, k_ok, rd6, a7;
    logic [11:0] t6;
    logic [7:0]  t4;
    logic [5:0]  s6;
    logic [3:0]  s4;
    logic [9:0]  sym;
    lane_enc_t   r;
    r    = '0;
    x    = b[4:0];
    y    = b[7:5];
    k28  = (x == 5'd28);
    k_ok = k && (k28 || (y == 3'd7 &&
           (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30)));
    t6 = '0;
    case (x)
      5'd0:  t6 = {6'b100111, 6'b011000};
      5'd1:  t6 = {6'b011101, 6'b100010};
      5'd2:  t6 = {6'b101101, 6'b010010};
      5'd3:  t6 = {6'b110001, 6'b110001};
      5'd4:  t6 = {6'b110101, 6'b001010};
      5'd5:  t6 = {6'b101001, 6'b101001};
      5'd6:  t6 = {6'b011001, 6'b011001};
      5'd7:  t6 = {6'b111000, 6'b000111};
      5'd8:  t6 = {6'b111001, 6'b000110};
      5'd9:  t6 = {6'b100101, 6'b100101};
      5'd10: t6 = {6'b010101, 6'b010101};
      5'd11: t6 = {6'b110100, 6'b110100};
      5'd12: t6 = {6'b001101, 6'b001101};
      5'd13: t6 = {6'b101100, 6'b101100};
      5'd14: t6 = {6'b011100, 6'b011100};
      5'd15: t6 = {6'b010111, 6'b101000};
      5'd16: t6 = {6'b011011, 6'b100100};
      5'd17: t6 = {6'b100011, 6'b100011};
      5'd18: t6 = {6'b010011, 6'b010011};
      5'd19: t6 = {6'b110010, 6'b110010};
      5'd20: t6 = {6'b001011, 6'b001011};
      5'd21: t6 = {6'b101010, 6'b101010};
      5'd22: t6 = {6'b011010, 6'b011010};
      5'd23: t6 = {6'b111010, 6'b000101};
      5'd24: t6 = {6'b110011, 6'b001100};
      5'd25: t6 = {6'b100110, 6'b100110};
      5'd26: t6 = {6'b010110, 6'b010110};
      5'd27: t6 = {6'b110110, 6'b001001};
      5'd28: t6 = {6'b001110, 6'b001110};
      5'd29: t6 = {6'b101110, 6'b010001};
      5'd30: t6 = {6'b011110, 6'b100001};
      5'd31: t6 = {6'b101011, 6'b010100};
      default: t6 = '0;
    endcase
    if (k_ok && k28) t6 = {6'b001111, 6'b110000};
    s6  = rd ? t6[5:0] : t6[11:6];
    rd6 = ($countones(s6) > 3) ? 1'b1 : ($countones(s6) < 3) ? 1'b0 : rd;

    // Alternate D.x.7 avoids a run of five equal bits across the sub-blocks.
    a7 = (y == 3'd7) &&
         ((!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
          ( rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
    t4 = '0;
    if (k_ok) begin
      case (y)
        3'd0: t4 = {4'b1011, 4'b0100};
        3'd1: t4 = {4'b0110, 4'b1001};
        3'd2: t4 = {4'b1010, 4'b0101};
        3'd3: t4 = {4'b1100, 4'b0011};
        3'd4: t4 = {4'b1101, 4'b0010};
        3'd5: t4 = {4'b0101, 4'b1010};
        3'd6: t4 = {4'b1001, 4'b0110};
        3'd7: t4 = {4'b0111, 4'b1000};
        default: t4 = '0;
      endcase
    end else if (a7) begin
      t4 = {4'b0111, 4'b1000};
    end else begin
      case (y)
        3'd0: t4 = {4'b1011, 4'b0100};
        3'd1: t4 = {4'b1001, 4'b1001};
        3'd2: t4 = {4'b0101, 4'b0101};
        3'd3: t4 = {4'b1100, 4'b0011};
        3'd4: t4 = {4'b1101, 4'b0010};
        3'd5: t4 = {4'b1010, 4'b1010};
        3'd6: t4 = {4'b0110, 4'b0110};
        3'd7: t4 = {4'b1110, 4'b0001};
        default: t4 = '0;
      endcase
    end
    s4   = rd6 ? t4[3:0] : t4[7:4];
    r.rd = ($countones(s4) > 2) ? 1'b1 : ($countones(s4) < 2) ? 1'b0 : rd6;

    // Symbol is held a-first; dataout wants a in bit 0.
    sym = {s6, s4};
    for (int j = 0; j < 10; j++) r.code[j] = sym[9-j];
    r.kerr = k && !k_ok;
    return r;
  endfunction

  logic                 accept;
  logic                 rd_q, rd_d, rd_run;
  lane_enc_t            lane_r;
  logic [10*LANES-1:0]  enc_code;
  logic [LANES-1:0]     enc_kerr;
  logic [10*LANES-1:0]  s1_code_q;
  logic [LANES-1:0]     s1_kerr_q;
  logic                 s1_valid_q, s1_rd_q;

  assign accept = ena | idle_ins;

  // NOTE: every variable gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_run   = rdforce ? rdin : rd_q;
    lane_r   = '0;
    enc_code = '0;
    enc_kerr = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_r = encode_lane(kin[i] | idle_ins,
                           idle_ins ? 8'hBC : datain[8*i +: 8], rd_run);
      enc_code[10*i +: 10] = lane_r.code;
      enc_kerr[i]          = lane_r.kerr;
      rd_run               = lane_r.rd;
    end
    rd_d = accept ? rd_run : rd_q;
  end

  assign rdcascade = rd_run;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  // The pipeline registers are reset along with the RD register so a reset
  // mid-stream discards in-flight words instead of replaying stale codes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_q       <= 1'b0;
      s1_code_q  <= '0;
      s1_kerr_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_rd_q    <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      s1_valid_q <= accept;
      if (accept) begin
        s1_code_q <= enc_code;
        s1_kerr_q <= enc_kerr;
        s1_rd_q   <= rd_run;
      end
    end
  end

  if (PIPE == 2) begin : g_pipe2
    logic [10*LANES-1:0] s2_code_q;
    logic [LANES-1:0]    s2_kerr_q;
    logic                s2_valid_q, s2_rd_q;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        s2_code_q  <= '0;
        s2_kerr_q  <= '0;
        s2_valid_q <= 1'b0;
        s2_rd_q    <= 1'b0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_code_q <= s1_code_q;
          s2_kerr_q <= s1_kerr_q;
          s2_rd_q   <= s1_rd_q;
        end
      end
    end

    assign dataout = s2_code_q;
    assign kerr    = s2_kerr_q;
    assign valid   = s2_valid_q;
    assign rdout   = s2_rd_q;
  end else begin : g_pipe1
    assign dataout = s1_code_q;
    assign kerr    = s1_kerr_q;
    assign valid   = s1_valid_q;
    assign rdout   = s1_rd_q;
  end

endmodule

// File: tb/tb_enc8b10b_lanes.sv
// ---------------------------------------------------------------------------
// tb_enc8b10b_lanes
//   Drives a PIPE=1 and a PIPE=2 instance from the same inputs and compares
//   both against a reference encoder built from the RD- code tables plus the
//   complement-on-RD+ rule, with disparity derived from ones counts.
// ---------------------------------------------------------------------------
module tb_enc8b10b_lanes;
  localparam int LANES = 2;

  typedef struct packed { logic [9:0] code; logic rd; logic kerr; } enc_t;
  typedef struct packed {
    logic [10*LANES-1:0] data;
    logic [LANES-1:0]    kerr;
    logic                valid;
    logic                rd;
  } out_t;

  // RD- forms, abcdei / fghj with a as the MSB.
  localparam logic [5:0] D6 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [3:0] D4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                                    4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] K4 [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100,
                                    4'b1101, 4'b0101, 4'b1001, 4'b0111};
  localparam logic [7:0] KLEGAL [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                                         8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  logic                clk = 1'b0;
  logic                reset_n, ena, idle_ins, rdin, rdforce;
  logic [LANES-1:0]    kin;
  logic [8*LANES-1:0]  datain;
  logic [10*LANES-1:0] dout1, dout2;
  logic [LANES-1:0]    kerr1, kerr2;
  logic                valid1, valid2, rdout1, rdout2, rdc1, rdc2;

  int   checks = 0;
  int   errors = 0;
  logic m_rd;
  out_t o1, o2;
  logic last_rdc;

  always #5 clk = ~clk;

  enc8b10b_lanes #(.LANES(LANES), .PIPE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .ena(ena), .idle_ins(idle_ins), .kin(kin),
    .datain(datain), .rdin(rdin), .rdforce(rdforce), .dataout(dout1),
    .kerr(kerr1), .valid(valid1), .rdout(rdout1), .rdcascade(rdc1));

  enc8b10b_lanes #(.LANES(LANES), .PIPE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .ena(ena), .idle_ins(idle_ins), .kin(kin),
    .datain(datain), .rdin(rdin), .rdforce(rdforce), .dataout(dout2),
    .kerr(kerr2), .valid(valid2), .rdout(rdout2), .rdcascade(rdc2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rd_after(input int ones, input int width, input logic rd);
    if (2 * ones > width) return 1'b1;
    if (2 * ones < width) return 1'b0;
    return rd;
  endfunction

  function automatic enc_t ref_enc(input logic k, input logic [7:0] b, input logic rd);
    enc_t       r;
    logic [4:0] x;
    logic [2:0] y;
    logic       legal, k28, comp6, comp4, rd6, alt;
    logic [5:0] six;
    logic [3:0] four;
    logic [9:0] sym;
    x = b[4:0];
    y = b[7:5];
    legal = 1'b0;
    for (int n = 0; n < 12; n++) if (k && b == KLEGAL[n]) legal = 1'b1;
    k28   = legal && (x == 5'd28);
    six   = k28 ? 6'b001111 : D6[x];
    comp6 = k28 || ($countones(six) != 3) || (x == 5'd7);
    if (rd && comp6) six = ~six;
    rd6 = rd_after($countones(six), 6, rd);
    alt = !legal && (y == 3'd7) &&
          ((!rd6 && (x inside {5'd17, 5'd18, 5'd20})) ||
           ( rd6 && (x inside {5'd11, 5'd13, 5'd14})));
    if (legal) begin
      four = K4[y]; comp4 = 1'b1;
    end else if (alt) begin
      four = 4'b0111; comp4 = 1'b1;
    end else begin
      four = D4[y]; comp4 = ($countones(four) != 2) || (y == 3'd3);
    end
    if (rd6 && comp4) four = ~four;
    r.rd = rd_after($countones(four), 4, rd6);
    sym  = {six, four};
    for (int j = 0; j < 10; j++) r.code[j] = sym[9-j];
    r.kerr = k && !legal;
    return r;
  endfunction

  // One clock: predict, check rdcascade before the edge, check outputs after.
  task automatic step(input string tag);
    logic acc, rd_run;
    enc_t e;
    out_t w;
    #1;
    acc    = reset_n && (ena || idle_ins);
    w      = '0;
    rd_run = rdforce ? rdin : m_rd;
    if (acc) begin
      for (int i = 0; i < LANES; i++) begin
        e = ref_enc(idle_ins | kin[i], idle_ins ? 8'hBC : datain[8*i +: 8], rd_run);
        w.data[10*i +: 10] = e.code;
        w.kerr[i]          = e.kerr;
        rd_run             = e.rd;
      end
      w.valid = 1'b1;
      w.rd    = rd_run;
      check({tag, ":rdcascade1"}, 32'(rdc1), 32'(rd_run));
      check({tag, ":rdcascade2"}, 32'(rdc2), 32'(rd_run));
    end
    last_rdc = rdc1;
    if (!reset_n) begin
      m_rd = 1'b0; o1 = '0; o2 = '0;
    end else begin
      if (o1.valid) o2 = o1; else o2.valid = 1'b0;
      if (acc) begin o1 = w; m_rd = rd_run; end else o1.valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check({tag, ":p1_data"},  32'(dout1),  32'(o1.data));
    check({tag, ":p1_kerr"},  32'(kerr1),  32'(o1.kerr));
    check({tag, ":p1_valid"}, 32'(valid1), 32'(o1.valid));
    check({tag, ":p1_rdout"}, 32'(rdout1), 32'(o1.rd));
    check({tag, ":p2_data"},  32'(dout2),  32'(o2.data));
    check({tag, ":p2_kerr"},  32'(kerr2),  32'(o2.kerr));
    check({tag, ":p2_valid"}, 32'(valid2), 32'(o2.valid));
    check({tag, ":p2_rdout"}, 32'(rdout2), 32'(o2.rd));
  endtask

  initial begin
    logic [20:0] held;
    int          r;
    logic [7:0]  byte_v;

    // Reset for 10 clocks.
    reset_n = 1'b0; ena = 1'b0; idle_ins = 1'b0; kin = '0; datain = '0;
    rdin = 1'b0; rdforce = 1'b0;
    for (int n = 0; n < 10; n++) step("reset");
    check("reset_valid1", 32'(valid1), 32'd0);
    check("reset_data2",  32'(dout2),  32'd0);

    // K28.5 on both lanes, repeating from RD-.
    reset_n = 1'b1; ena = 1'b1; kin = 2'b11; datain = 16'hBCBC;
    for (int n = 0; n < 3; n++) begin
      step("k285");
      check("k285_p1_code", 32'(dout1), 32'({10'h283, 10'h17C}));
      check("k285_p1_rd",   32'(rdout1), 32'd0);
    end
    check("k285_p2_code", 32'(dout2), 32'({10'h283, 10'h17C}));

    // D0.0 and neutral D21.5.
    kin = 2'b00; datain = 16'h0000;
    step("d00");
    check("d00_code", 32'(dout1), 32'({10'h0B9, 10'h0B9}));
    check("d00_rd",   32'(rdout1), 32'd0);
    datain = 16'hB5B5;
    step("d215");
    check("d215_code", 32'(dout1), 32'({10'h155, 10'h155}));

    // Idle insertion, then an empty cycle holding outputs.
    ena = 1'b0; idle_ins = 1'b1; datain = 16'h1234; kin = 2'b00;
    for (int n = 0; n < 4; n++) begin
      step("idle");
      check("idle_code", 32'(dout1), 32'({10'h283, 10'h17C}));
    end
    idle_ins = 1'b0;
    held = {dout1, rdout1};
    step("hold");
    check("hold_valid", 32'(valid1), 32'd0);
    check("hold_data",  32'({dout1, rdout1}), 32'(held));

    // Invalid K flags its lane only; legal K23.7 does not.
    ena = 1'b1; kin = 2'b01; datain = 16'h0000;
    step("badk");
    check("badk_kerr", 32'(kerr1), 32'(2'b01));
    check("badk_code", 32'(dout1), 32'({10'h0B9, 10'h0B9}));
    kin = 2'b11; datain = 16'hF7F7;
    step("k237");
    check("k237_kerr", 32'(kerr1), 32'd0);

    // Forced starting RD+.
    rdforce = 1'b1; rdin = 1'b1; kin = 2'b01; datain = 16'h00BC;
    step("force");
    check("force_lane0", 32'(dout1[9:0]), 32'(10'h283));
    check("force_cascade", 32'(rdout1), 32'(last_rdc));
    rdforce = 1'b0; rdin = 1'b0;

    // Reset mid-stream.
    kin = 2'b11; datain = 16'hBCBC;
    step("pre_rst");
    reset_n = 1'b0;
    step("mid_rst");
    check("mid_rst_valid2", 32'(valid2), 32'd0);
    check("mid_rst_data2",  32'(dout2),  32'd0);
    check("mid_rst_rd2",    32'(rdout2), 32'd0);
    reset_n = 1'b1; kin = 2'b01; datain = 16'h00BC;
    step("post_rst");
    check("post_rst_p1", 32'(dout1[9:0]), 32'(10'h17C));
    ena = 1'b0;
    step("post_rst2");
    check("post_rst_p2", 32'(dout2[9:0]), 32'(10'h17C));

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      r        = $urandom_range(0, 99);
      ena      = (r < 75);
      idle_ins = ($urandom_range(0, 9) == 0);
      rdforce  = ($urandom_range(0, 9) == 0);
      rdin     = 1'($urandom_range(0, 1));
      reset_n  = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < LANES; i++) begin
        r = $urandom_range(0, 3);
        if (r == 0) begin
          kin[i] = 1'b1; byte_v = KLEGAL[$urandom_range(0, 11)];
        end else begin
          kin[i] = (r == 1); byte_v = 8'($urandom_range(0, 255));
        end
        datain[8*i +: 8] = byte_v;
      end
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
